baccarat_deal_ctrl: RTL and testbench

Sequencing controller for one baccarat hand. It drives the card-load strobes for the player and dealer card registers, which feed the two `scorehand` instances. It reads back the combinational scores and applies the third-card drawing rules, then latches the win lights. It sits between the card source / card registers and the display, and replaces ad-hoc per-clock dealing logic.

---
 rtl/baccarat_deal_ctrl.sv | 127 ++++++++++++
 tb/tb_baccarat_deal_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat hand sequencer: card-load strobes, third-card rules and win lights.
// Optional completed-hand counter is enabled by defining HAND_COUNT_EN.
module baccarat_deal_ctrl (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       advance,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clear_cards,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done,
  output logic [7:0] hands_played
);

  typedef enum logic [3:0] {
    P1, D1, P2, D2, CHK, P3, DCHK, D3, CMP, DONE
  } state_t;

  state_t state, state_nxt;

  // Dealer drawing table once the player has taken a third card.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] card3);
    logic [3:0] v3;
    v3 = (card3 >= 4'd10) ? 4'd0 : card3;
    case (ds)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (v3 != 4'd8);
      4'd4:             dealer_draws = (v3 >= 4'd2) && (v3 <= 4'd7);
      4'd5:             dealer_draws = (v3 >= 4'd4) && (v3 <= 4'd7);
      4'd6:             dealer_draws = (v3 >= 4'd6) && (v3 <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  endfunction

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state <= P1;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (advance) begin
      case (state)
        P1:   state_nxt = D1;
        D1:   state_nxt = P2;
        P2:   state_nxt = D2;
        D2:   state_nxt = CHK;
        CHK: begin
          if (pscore >= 4'd8 || dscore >= 4'd8) state_nxt = CMP;
          else if (pscore <= 4'd5)              state_nxt = P3;
          else if (dscore <= 4'd5)              state_nxt = D3;
          else                                  state_nxt = CMP;
        end
        P3:   state_nxt = DCHK;
        DCHK: state_nxt = dealer_draws(dscore, pcard3) ? D3 : CMP;
        D3:   state_nxt = CMP;
        CMP:  state_nxt = DONE;
        DONE: state_nxt = P1;
        default: state_nxt = P1;
      endcase
    end
  end

  // Mealy strobes, suppressed while reset is held.
  always_comb begin
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    clear_cards = 1'b0;
    if (advance && !reset) begin
      case (state)
        P1:   load_pcard1 = 1'b1;
        D1:   load_dcard1 = 1'b1;
        P2:   load_pcard2 = 1'b1;
        D2:   load_dcard2 = 1'b1;
        P3:   load_pcard3 = 1'b1;
        D3:   load_dcard3 = 1'b1;
        DONE: clear_cards = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else if (advance && state == CMP) begin
      player_win_light <= (pscore >= dscore);
      dealer_win_light <= (dscore >= pscore);
    end else if (advance && state == DONE) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  end

  assign done = (state == DONE);

`ifdef HAND_COUNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] hand_cnt;

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset)                        hand_cnt <= 8'd0;
    else if (advance && state == CMP) hand_cnt <= sat_inc(hand_cnt);
  end

  assign hands_played = hand_cnt;
`else
  assign hands_played = 8'd0;
`endif

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Bench for baccarat_deal_ctrl: emulates card registers and scorehand, and checks
// every cycle against a rule-level model of a hand.
module tb_baccarat_deal_ctrl;

  logic       slow_clock = 1'b0;
  logic       reset, advance;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clear_cards, player_win_light, dealer_win_light, done;
  logic [7:0] hands_played;

  int checks = 0;
  int failures = 0;

  always #5 slow_clock = ~slow_clock;

  baccarat_deal_ctrl dut (
    .slow_clock(slow_clock), .reset(reset), .advance(advance),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .clear_cards(clear_cards), .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light), .done(done), .hands_played(hands_played)
  );

  function automatic int cval(input logic [3:0] r);
    return (r >= 4'd10) ? 0 : int'(r);
  endfunction

  // Card source and card registers feeding the score inputs.
  logic [3:0] src_p [3];
  logic [3:0] src_d [3];
  logic [3:0] pc [3];
  logic [3:0] dc [3];

  always @(posedge slow_clock or posedge reset) begin
    if (reset || clear_cards) begin
      for (int i = 0; i < 3; i++) begin
        pc[i] <= 4'd0;
        dc[i] <= 4'd0;
      end
    end else begin
      if (load_pcard1) pc[0] <= src_p[0];
      if (load_pcard2) pc[1] <= src_p[1];
      if (load_pcard3) pc[2] <= src_p[2];
      if (load_dcard1) dc[0] <= src_d[0];
      if (load_dcard2) dc[1] <= src_d[1];
      if (load_dcard3) dc[2] <= src_d[2];
    end
  end

  always_comb begin
    pscore = 4'((cval(pc[0]) + cval(pc[1]) + cval(pc[2])) % 10);
    dscore = 4'((cval(dc[0]) + cval(dc[1]) + cval(dc[2])) % 10);
    pcard3 = pc[2];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Expected outputs per cycle; strobe bits {clear,d3,p3,d2,p2,d1,p1}.
  typedef struct {
    logic [6:0] strb;
    logic       dn;
    logic       pl;
    logic       dl;
    logic [7:0] hp;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] strb_now;
  assign strb_now = {clear_cards, load_dcard3, load_pcard3, load_dcard2,
                     load_pcard2, load_dcard1, load_pcard1};

  always @(negedge slow_clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("strobes", 32'(strb_now), 32'(e.strb));
      check("done", 32'(done), 32'(e.dn));
      check("player_light", 32'(player_win_light), 32'(e.pl));
      check("dealer_light", 32'(dealer_win_light), 32'(e.dl));
      check("hands_played", 32'(hands_played), 32'(e.hp));
    end
  end

  int exp_hands = 0;

  // Rule-level model of one hand: who draws and the final totals.
  task automatic model_hand(input logic [3:0] p1, p2, p3, d1, d2, d3,
                            output bit pdraw, output bit ddraw, output int pt, output int dt);
    int pt0, dt0, v3, lo;
    bit natural;
    pt0 = (cval(p1) + cval(p2)) % 10;
    dt0 = (cval(d1) + cval(d2)) % 10;
    natural = (pt0 >= 8) || (dt0 >= 8);
    pdraw = !natural && (pt0 <= 5);
    v3 = cval(p3);
    if (pdraw) begin
      if (dt0 <= 2)      ddraw = 1'b1;
      else if (dt0 == 3) ddraw = (v3 != 8);
      else if (dt0 <= 6) begin
        lo = 2 * (dt0 - 3);
        ddraw = (v3 >= lo) && (v3 <= 7);
      end else           ddraw = 1'b0;
    end else begin
      ddraw = !natural && (dt0 <= 5);
    end
    pt = pdraw ? (pt0 + v3) % 10 : pt0;
    dt = ddraw ? (dt0 + cval(d3)) % 10 : dt0;
  endtask

  // Plays one hand with advance high, optionally stalling at a step or resetting there.
  task automatic run_hand(input logic [3:0] p1, p2, p3, d1, d2, d3,
                          input int stall_at, input int stall_len, input int abort_at,
                          output int done_k, output int pc3_k, output int dc3_k,
                          output bit pl_final, output bit dl_final);
    bit pdraw, ddraw, pl, dl;
    int pt, dt, last;
    int steps[$];
    exp_t e;
    model_hand(p1, p2, p3, d1, d2, d3, pdraw, ddraw, pt, dt);
    pl = (pt >= dt);
    dl = (dt >= pt);
    src_p[0] = p1; src_p[1] = p2; src_p[2] = p3;
    src_d[0] = d1; src_d[1] = d2; src_d[2] = d3;
    steps = '{1, 2, 4, 8, 0};
    if (pdraw) begin
      steps.push_back(16);
      steps.push_back(0);
    end
    if (ddraw) steps.push_back(32);
    steps.push_back(0);
    steps.push_back(64);
    last = steps.size() - 1;
    done_k = -1; pc3_k = -1; dc3_k = -1;
    pl_final = 1'b0; dl_final = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k == abort_at) begin
        advance = 1'b1;
        reset = 1'b1;
        #2;
        check("rst_strobes", 32'(strb_now), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lights", 32'({player_win_light, dealer_win_light}), 32'd0);
        check("rst_hands", 32'(hands_played), 32'd0);
        exp_hands = 0;
        @(posedge slow_clock); #1;
        reset = 1'b0;
        return;
      end
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          advance = 1'b0;
          e.strb = 7'd0; e.dn = (k == last); e.pl = (k == last) && pl;
          e.dl = (k == last) && dl; e.hp = 8'(exp_hands);
          exp_q.push_back(e);
          @(negedge slow_clock);
          @(posedge slow_clock); #1;
        end
      end
      advance = 1'b1;
`ifdef HAND_COUNT_EN
      if (k == last && exp_hands < 255) exp_hands++;
`endif
      e.strb = 7'(steps[k]); e.dn = (k == last); e.pl = (k == last) && pl;
      e.dl = (k == last) && dl; e.hp = 8'(exp_hands);
      exp_q.push_back(e);
      @(negedge slow_clock);
      if (done && done_k < 0) begin
        done_k = k;
        pl_final = player_win_light;
        dl_final = dealer_win_light;
      end
      if (load_pcard3) pc3_k = k;
      if (load_dcard3) dc3_k = k;
      @(posedge slow_clock); #1;
    end
    advance = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk, p3k, d3k;
    bit plf, dlf;
    reset = 1'b1;
    advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_p[i] = 4'd0;
      src_d[i] = 4'd0;
    end
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    check("reset_strobes", 32'(strb_now), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_lights", 32'({player_win_light, dealer_win_light}), 32'd0);
    check("reset_hands", 32'(hands_played), 32'd0);
    @(posedge slow_clock); #1;
    reset = 1'b0;

    // Natural: 8 vs 5.
    run_hand(4, 4, 0, 2, 3, 0, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    check("nat_done_cycle", 32'(dk), 32'd6);
    check("nat_no_p3", 32'(p3k), 32'hFFFF_FFFF);
    check("nat_no_d3", 32'(d3k), 32'hFFFF_FFFF);
    check("nat_lights", 32'({plf, dlf}), 32'b10);

    // Dealer stands on 3 against an 8: 3 vs 3 tie.
    run_hand(2, 3, 8, 1, 2, 0, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    check("d3v8_p3_cycle", 32'(p3k), 32'd5);
    check("d3v8_no_d3", 32'(d3k), 32'hFFFF_FFFF);
    check("d3v8_done_cycle", 32'(dk), 32'd8);
    check("d3v8_lights", 32'({plf, dlf}), 32'b11);

    // Player stands on 7, dealer draws a King on 5.
    run_hand(3, 4, 0, 2, 3, 13, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    check("pstand_d3_cycle", 32'(d3k), 32'd5);
    check("pstand_done_cycle", 32'(dk), 32'd7);
    check("pstand_lights", 32'({plf, dlf}), 32'b10);

    // Dealer on 4 with v3 = 0 (Queen) stands: 2 vs 4.
    run_hand(1, 1, 12, 1, 3, 0, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    check("d4q_no_d3", 32'(d3k), 32'hFFFF_FFFF);
    check("d4q_lights", 32'({plf, dlf}), 32'b01);

    // Dealer on 4 with v3 = 2 draws: 4 vs 9.
    run_hand(1, 1, 2, 1, 3, 5, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    check("d4two_d3_cycle", 32'(d3k), 32'd7);
    check("d4two_done_cycle", 32'(dk), 32'd9);
    check("d4two_lights", 32'({plf, dlf}), 32'b01);

    // Five-cycle stall in D2, then the natural hand completes normally.
    run_hand(4, 4, 0, 2, 3, 0, 3, 5, -1, dk, p3k, d3k, plf, dlf);
    check("stall_lights", 32'({plf, dlf}), 32'b10);

    // Reset while in P3, then the next advance loads the first player card.
    run_hand(2, 3, 8, 1, 2, 0, -1, 0, 5, dk, p3k, d3k, plf, dlf);
    advance = 1'b1;
    @(negedge slow_clock);
    check("post_reset_p1", 32'(strb_now), 32'd1);
    check("post_reset_hands", 32'(hands_played), 32'd0);
    reset = 1'b1;
    @(posedge slow_clock); #1;
    reset = 1'b0;
    advance = 1'b0;

    // Three hands for the counter.
    for (int h = 0; h < 3; h++)
      run_hand(4, 4, 0, 2, 3, 0, -1, 0, -1, dk, p3k, d3k, plf, dlf);
    @(negedge slow_clock);
`ifdef HAND_COUNT_EN
    check("count_three", 32'(hands_played), 32'd3);
`else
    check("count_tied_zero", 32'(hands_played), 32'd0);
`endif
    reset = 1'b1;
    #2;
    check("count_reset", 32'(hands_played), 32'd0);
    @(posedge slow_clock); #1;
    reset = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
